// File: rtl/logic_unit_pipe.sv
// Registered 8-op bitwise logic unit with a 2-entry (head + skid) valid/ready output buffer.
// Optional macro LU_REDUCE_EN adds port r (AND-reduction of y), stored per entry.
module logic_unit_pipe #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         zero
`ifdef LU_REDUCE_EN
    ,
    output logic         r
`endif
);

`ifdef LU_REDUCE_EN
    localparam int unsigned EW = W + 2;
`else
    localparam int unsigned EW = W + 1;
`endif
    // Entry layout: {[r,] zero, y}; reset entry has only the zero flag set.
    localparam logic [EW-1:0] RST_ENTRY = EW'(1) << W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e          occ_q;
    logic [EW-1:0] head_q;
    logic [EW-1:0] skid_q;
    logic [EW-1:0] res_d;
    logic [W-1:0]  res_y;
    logic          push;
    logic          pop;

    always_comb begin
        res_y = '0;
        unique case (op)
            3'b000: res_y = a & b;
            3'b001: res_y = a | b;
            3'b010: res_y = a ^ b;
            3'b011: res_y = ~(a & b);
            3'b100: res_y = ~(a | b);
            3'b101: res_y = ~(a ^ b);
            3'b110: res_y = ~a;
            3'b111: res_y = a;
            default: res_y = '0;
        endcase
`ifdef LU_REDUCE_EN
        res_d = {(&res_y), (res_y == '0), res_y};
`else
        res_d = {(res_y == '0), res_y};
`endif
    end

    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= RST_ENTRY;
            skid_q <= RST_ENTRY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= res_d;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    // Simultaneous push/pop replaces the head in place.
                    if (push && pop) begin
                        head_q <= res_d;
                    end else if (push) begin
                        skid_q <= res_d;
                        occ_q  <= OCC_FULL;
                    end else if (pop) begin
                        occ_q  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_q <= skid_q;
                        occ_q  <= OCC_ONE;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign y    = head_q[W-1:0];
    assign zero = head_q[W];
`ifdef LU_REDUCE_EN
    assign r    = head_q[W+1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus a randomized queue-model run.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
`ifdef LU_REDUCE_EN
    logic       r;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic_unit_pipe #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
`ifdef LU_REDUCE_EN
        ,
        .r         (r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the operation table applied to whole operands.
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
`ifdef LU_REDUCE_EN
        total++; if (r !== 1'b0) begin bad++; $display("FAIL reset_r got=%b exp=0", r); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ops;
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        a = 8'hF0; b = 8'h3C; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            total++; if (out_valid !== 1'b1 || y !== exp_tab[i]) begin
                bad++; $display("FAIL ops_%0d got=%b/%h exp=1/%h", i, out_valid, y, exp_tab[i]);
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ops_ready_%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_zero;
        a = 8'hAA; b = 8'h55; op = 3'd0; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        total++; if (y !== 8'h00 || zero !== 1'b1) begin bad++; $display("FAIL zero_and got=%h/%b exp=00/1", y, zero); end
        op = 3'd1;
        tick();
        total++; if (y !== 8'hFF || zero !== 1'b0) begin bad++; $display("FAIL zero_or got=%h/%b exp=FF/0", y, zero); end
`ifdef LU_REDUCE_EN
        total++; if (r !== 1'b1) begin bad++; $display("FAIL zero_r got=%b exp=1", r); end
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; b = 8'hFF; op = 3'd0;
        a = 8'h01;
        tick();
        total++; if (in_ready !== 1'b1 || y !== 8'h01) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/01", in_ready, y); end
        a = 8'h02;
        tick();
        total++; if (in_ready !== 1'b0 || y !== 8'h01) begin bad++; $display("FAIL bp_full got=%b/%h exp=0/01", in_ready, y); end
        a = 8'h03;
        tick();
        total++; if (in_ready !== 1'b0 || y !== 8'h01) begin bad++; $display("FAIL bp_hold got=%b/%h exp=0/01", in_ready, y); end
        out_ready = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1 || y !== 8'h02) begin bad++; $display("FAIL bp_pop1 got=%b/%h exp=1/02", in_ready, y); end
        tick();
        total++; if (out_valid !== 1'b1 || y !== 8'h03) begin bad++; $display("FAIL bp_pop2 got=%b/%h exp=1/03", out_valid, y); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_push_pop;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'hFF; op = 3'd0;
        tick();
        a = 8'h22; out_ready = 1'b1;
        tick();
        total++; if (y !== 8'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL pushpop got=%h/%b/%b exp=22/1/1", y, out_valid, in_ready);
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0; in_valid = 1'b1; b = 8'h00; op = 3'd7;
        a = 8'hA5;
        tick();
        a = 8'h5A;
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_full got=%b exp=0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || y !== 8'h00 || zero !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL ar_immediate got=%b/%h/%b/%b exp=0/00/1/1", out_valid, y, zero, in_ready);
        end
`ifdef LU_REDUCE_EN
        total++; if (r !== 1'b0) begin bad++; $display("FAIL ar_r got=%b exp=0", r); end
`endif
        tick();
        rst_n = 1'b1;
        a = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || y !== 8'h3C) begin bad++; $display("FAIL ar_new got=%b/%h exp=1/3C", out_valid, y); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_no_stale got=%b exp=0", out_valid); end
    endtask

    task automatic test_isolation;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op = 3'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick();
            total++; if (out_valid !== 1'b1 || y !== 8'hCC) begin
                bad++; $display("FAIL iso_%0d got=%b/%h exp=1/CC", i, out_valid, y);
            end
        end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL iso_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        logic [7:0] e;
        bit         push;
        bit         pop;
        for (int i = 0; i < 400; i++) begin
            if (i >= 396) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            #1;
            total++; if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_flags_%0d got=%b/%b exp=%b/%b", i, in_ready, out_valid, q.size() != 2, q.size() != 0);
            end
            if (q.size() != 0) begin
                e = q[0];
                total++; if (y !== e || zero !== (e == 8'h00)) begin
                    bad++; $display("FAIL rnd_data_%0d got=%h/%b exp=%h/%b", i, y, zero, e, e == 8'h00);
                end
`ifdef LU_REDUCE_EN
                total++; if (r !== (e == 8'hFF)) begin bad++; $display("FAIL rnd_r_%0d got=%b exp=%b", i, r, e == 8'hFF); end
`endif
            end
            push = in_valid && (q.size() != 2);
            pop  = out_ready && (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref_op(op, a, b));
            @(posedge clk);
            #1;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_end got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero();
        test_backpressure();
        test_push_pop();
        test_async_reset();
        test_isolation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
